// File: rtl/beat_detector_pkg.sv
// Shared constants for the beat detection path: sample/interval widths and FSM states.
// NBIT is the stream sample width used by data_rom and every downstream stage.
package beat_detector_pkg;

    localparam int NBIT = 12;
    localparam int IBIT = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        PEAK    = 3'd2,
        REFRACT = 3'd3,
        DONE    = 3'd4
    } beat_state_e;

    function automatic logic [IBIT-1:0] sat_inc(input logic [IBIT-1:0] v);
        return (&v) ? v : v + IBIT'(1);
    endfunction

endpackage

// File: rtl/moving_avg.sv
// Power-of-two moving average: shift window, running sum, registered average.
// avg_valid pulses one cycle after each accepted sample once the window has filled.
module moving_avg #(
    parameter int NBIT     = 12,
    parameter int LOG2_WIN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [NBIT-1:0] in_data,
    output logic            avg_valid,
    output logic [NBIT-1:0] avg
);

    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = NBIT + LOG2_WIN;
    localparam int FW  = LOG2_WIN + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(WIN);
    localparam logic [FW-1:0] FILL_LAST = FW'(WIN - 1);

    logic [NBIT-1:0] win_q [WIN];
    logic [NBIT-1:0] win_d [WIN];
    logic [SW-1:0]   sum_q, sum_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [NBIT-1:0] avg_q, avg_d;
    logic            avg_valid_q, avg_valid_d;

    always_comb begin
        win_d       = win_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (in_valid) begin
            // The sum always contains the oldest entry, so this never underflows.
            sum_d    = sum_q + SW'(in_data) - SW'(win_q[WIN-1]);
            win_d[0] = in_data;
            for (int i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
            if (fill_q != FILL_FULL) fill_d = fill_q + FW'(1);
            avg_d       = NBIT'(sum_d >> LOG2_WIN);
            avg_valid_d = (fill_q >= FILL_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg       = avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/beat_detector.sv
// Peak detector on the smoothed sample stream; reports inter-beat interval in samples.
// Define BEAT_AVG_EN to average the last four intervals onto interval_avg.
module beat_detector
    import beat_detector_pkg::*;
#(
    parameter int LOG2_WIN    = 2,
    parameter int THRESH      = 2048,
    parameter int HYST        = 128,
    parameter int REFRACT_LEN = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_valid,
    input  logic [NBIT-1:0] sample_in,
    input  logic            over_in,
    output logic            beat,
    output logic [IBIT-1:0] interval,
    output logic [IBIT-1:0] interval_avg,
    output logic [15:0]     beat_count,
    output logic            done
);

    localparam logic [NBIT-1:0] TH_HI = NBIT'(THRESH);
    localparam logic [NBIT-1:0] TH_LO = NBIT'(THRESH - HYST);
    localparam int              RBIT  = $clog2(REFRACT_LEN + 1);
    localparam logic [RBIT-1:0] RLAST = RBIT'(REFRACT_LEN - 1);

    beat_state_e     state_q, state_d;
    logic [NBIT-1:0] peak_max_q, peak_max_d;
    logic [IBIT-1:0] ref_age_q, ref_age_d;
    logic [IBIT-1:0] cand_age_q, cand_age_d;
    logic [IBIT-1:0] pk_dist_q, pk_dist_d;
    logic            have_ref_q, have_ref_d;
    logic [RBIT-1:0] refr_q, refr_d;
    logic            beat_q, beat_d;
    logic [IBIT-1:0] interval_q, interval_d;
    logic [15:0]     beat_count_q, beat_count_d;
    logic            done_q, done_d;
    logic [IBIT-1:0] ref_now, cand_now;

    logic            ma_in_valid;
    logic            avg_valid;
    logic [NBIT-1:0] avg;

    assign ma_in_valid = sample_valid & ~over_in & (state_q != DONE);

    moving_avg #(.NBIT(NBIT), .LOG2_WIN(LOG2_WIN)) u_avg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ma_in_valid),
        .in_data   (sample_in),
        .avg_valid (avg_valid),
        .avg       (avg)
    );

    // Ages are distances of the current averaged sample from the reference peak and
    // from the open candidate peak; interval is snapshotted when the candidate moves.
    always_comb begin
        state_d      = state_q;
        peak_max_d   = peak_max_q;
        ref_age_d    = ref_age_q;
        cand_age_d   = cand_age_q;
        pk_dist_d    = pk_dist_q;
        have_ref_d   = have_ref_q;
        refr_d       = refr_q;
        beat_d       = 1'b0;
        interval_d   = interval_q;
        beat_count_d = beat_count_q;
        done_d       = done_q;
        ref_now      = sat_inc(ref_age_q);
        cand_now     = sat_inc(cand_age_q);
        if (over_in) begin
            state_d = DONE;
            done_d  = 1'b1;
        end else if (avg_valid) begin
            ref_age_d  = ref_now;
            cand_age_d = cand_now;
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (avg >= TH_HI) begin
                        state_d    = PEAK;
                        peak_max_d = avg;
                        pk_dist_d  = ref_now;
                        cand_age_d = '0;
                    end
                end
                PEAK: begin
                    if (avg > peak_max_q) begin
                        peak_max_d = avg;
                        pk_dist_d  = ref_now;
                        cand_age_d = '0;
                    end else if (avg < TH_LO) begin
                        ref_age_d  = cand_now;
                        have_ref_d = 1'b1;
                        if (have_ref_q) begin
                            beat_d       = 1'b1;
                            interval_d   = pk_dist_q;
                            beat_count_d = beat_count_q + 16'd1;
                            refr_d       = '0;
                            state_d      = REFRACT;
                        end else begin
                            state_d = ARMED;
                        end
                    end
                end
                REFRACT: begin
                    if (refr_q == RLAST) state_d = ARMED;
                    else                 refr_d  = refr_q + RBIT'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            peak_max_q   <= '0;
            ref_age_q    <= '0;
            cand_age_q   <= '0;
            pk_dist_q    <= '0;
            have_ref_q   <= 1'b0;
            refr_q       <= '0;
            beat_q       <= 1'b0;
            interval_q   <= '0;
            beat_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            peak_max_q   <= peak_max_d;
            ref_age_q    <= ref_age_d;
            cand_age_q   <= cand_age_d;
            pk_dist_q    <= pk_dist_d;
            have_ref_q   <= have_ref_d;
            refr_q       <= refr_d;
            beat_q       <= beat_d;
            interval_q   <= interval_d;
            beat_count_q <= beat_count_d;
            done_q       <= done_d;
        end
    end

    assign beat       = beat_q;
    assign interval   = interval_q;
    assign beat_count = beat_count_q;
    assign done       = done_q;

`ifdef BEAT_AVG_EN
    logic [IBIT-1:0] hist_q [4];
    logic [IBIT-1:0] hist_d [4];
    logic [IBIT+1:0] hsum_q, hsum_d;
    logic [2:0]      hcnt_q, hcnt_d;
    logic [IBIT-1:0] iavg_q, iavg_d;

    // Three entries divide by four, as if the missing slot held zero.
    always_comb begin
        hist_d = hist_q;
        hsum_d = hsum_q;
        hcnt_d = hcnt_q;
        iavg_d = iavg_q;
        if (beat_d) begin
            hsum_d    = hsum_q + (IBIT+2)'(interval_d) - (IBIT+2)'(hist_q[3]);
            hist_d[0] = interval_d;
            for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
            if (hcnt_q != 3'd4) hcnt_d = hcnt_q + 3'd1;
            case (hcnt_d)
                3'd1:    iavg_d = IBIT'(hsum_d);
                3'd2:    iavg_d = IBIT'(hsum_d >> 1);
                default: iavg_d = IBIT'(hsum_d >> 2);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            hsum_q <= '0;
            hcnt_q <= '0;
            iavg_q <= '0;
        end else begin
            hist_q <= hist_d;
            hsum_q <= hsum_d;
            hcnt_q <= hcnt_d;
            iavg_q <= iavg_d;
        end
    end

    assign interval_avg = iavg_q;
`else
    assign interval_avg = interval_q;
`endif

endmodule

// File: tb/tb_beat_detector.sv
// Directed bench for beat_detector: reset, periodic pulses, refractory, hysteresis,
// interval saturation, end-of-stream and mid-stream reset.
module tb_beat_detector;
    import beat_detector_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            sample_valid;
    logic [NBIT-1:0] sample_in;
    logic            over_in;
    logic            beat;
    logic [IBIT-1:0] interval;
    logic [IBIT-1:0] interval_avg;
    logic [15:0]     beat_count;
    logic            done;

    int n_vec = 0;
    int n_err = 0;
    int beats_seen = 0;
    int b0;

    always #10 clk = ~clk;

    beat_detector dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .over_in      (over_in),
        .beat         (beat),
        .interval     (interval),
        .interval_avg (interval_avg),
        .beat_count   (beat_count),
        .done         (done)
    );

    always @(negedge clk) if (beat === 1'b1) beats_seen++;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed(input int v);
        sample_in    = NBIT'(v);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int tri_s(input int t);
        if (t <= 25)      return 500 + 100 * t;
        else if (t <= 50) return 500 + 100 * (50 - t);
        else              return 500;
    endfunction

    // One 200-sample period; a confirmed pulse closes on the averaged sample t=38,
    // so the beat pulse is visible right after sample t=39 and gone after t=40.
    task automatic send_period(input bit exp_beat, input bit bump, input string tag);
        int start;
        int v;
        start = beats_seen;
        for (int t = 0; t < 200; t++) begin
            v = tri_s(t);
            if (bump && t >= 60 && t <= 63) v = 3000;
            feed(v);
            if (exp_beat && t == 39) chk({tag, "_beat_hi"}, beat, 1);
            if (exp_beat && t == 40) chk({tag, "_beat_lo"}, beat, 0);
        end
        chk({tag, "_nbeats"}, beats_seen - start, exp_beat ? 1 : 0);
    endtask

    task automatic reset_burst();
        rst = 1'b1;
        repeat (3) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample_in    = NBIT'($urandom);
            over_in      = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        chk("rst_beat", beat, 0);
        chk("rst_done", done, 0);
        chk("rst_interval", interval, 0);
        chk("rst_interval_avg", interval_avg, 0);
        chk("rst_beat_count", beat_count, 0);
        rst          = 1'b0;
        over_in      = 1'b0;
        sample_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        over_in      = 1'b0;
        reset_burst();

        b0 = beats_seen;
        repeat (100) feed(1000);
        chk("const_no_beat", beats_seen - b0, 0);

        for (int p = 0; p < 5; p++) send_period(p != 0, 1'b0, "periodic");
        chk("periodic_count", beat_count, 4);
        chk("periodic_interval", interval, 200);
        chk("periodic_iavg", interval_avg, 200);

        send_period(1'b1, 1'b1, "refr_bump");
        chk("refr_count_a", beat_count, 5);
        send_period(1'b1, 1'b0, "refr_next");
        chk("refr_count_b", beat_count, 6);
        chk("refr_interval", interval, 200);

        // Avg rises to 2100 on the 4th sample and wobbles 2000..2100, then 1950 (above 1920).
        b0 = beats_seen;
        repeat (8) feed(2100);
        repeat (3) begin
            repeat (4) feed(2000);
            repeat (4) feed(2100);
        end
        repeat (8) feed(1950);
        chk("hyst_open", beats_seen - b0, 0);
        feed(500);
        feed(500);
        chk("hyst_beat", beat, 1);
        chk("hyst_interval", interval, 177);
        chk("hyst_count", beat_count, 7);
`ifdef BEAT_AVG_EN
        chk("hyst_iavg", interval_avg, 194);
`else
        chk("hyst_iavg", interval_avg, 177);
`endif
        repeat (60) feed(500);
        chk("hyst_single", beats_seen - b0, 1);

        repeat (70000) feed(500);
        send_period(1'b1, 1'b0, "sat");
        chk("sat_interval", interval, 16'hFFFF);
        chk("sat_count", beat_count, 8);
`ifdef BEAT_AVG_EN
        chk("sat_iavg", interval_avg, 16528);
`else
        chk("sat_iavg", interval_avg, 16'hFFFF);
`endif

        b0 = beats_seen;
        for (int t = 0; t <= 30; t++) feed(tri_s(t));
        chk("over_pre_done", done, 0);
        over_in = 1'b1;
        feed(tri_s(31));
        over_in = 1'b0;
        chk("over_done", done, 1);
        chk("over_beat", beat, 0);
        for (int t = 32; t <= 60; t++) feed(tri_s(t));
        chk("over_done_sticky", done, 1);
        chk("over_no_beat", beats_seen - b0, 0);
        chk("over_count", beat_count, 8);

        reset_burst();
        send_period(1'b0, 1'b0, "post_rst_first");
        chk("post_rst_count0", beat_count, 0);
        send_period(1'b1, 1'b0, "post_rst_second");
        chk("post_rst_count1", beat_count, 1);
        chk("post_rst_interval", interval, 200);
        chk("post_rst_iavg", interval_avg, 200);
        chk("post_rst_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
